// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo write-port arbiter.
// Optional per-producer beat counters are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned STAT_W = 16;

  // Width of a producer index; at least one bit even for a single producer.
  function automatic int unsigned grant_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Beat counter width; holds 0..MAX_BURST-1 with headroom.
  function automatic int unsigned beat_w(input int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [grant_w(NUM_REQ)-1:0] last_grant_i,
  output logic [grant_w(NUM_REQ)-1:0] pick_c_o,
  output logic                        any_req_c_o
);

  localparam int unsigned GRANT_W = grant_w(NUM_REQ);

  int                 idx;
  logic [NUM_REQ-1:0] shifted;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick_c_o    = '0;
    any_req_c_o = |req_i;
    idx         = 0;
    shifted     = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = int'(last_grant_i) + i;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      shifted = req_i >> idx;
      if (shifted[0]) pick_c_o = GRANT_W'(idx);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the fifo write port; data passes through.
// Define FIFO_ARB_STATS_EN to add saturating per-producer transfer counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        io_clk,
  input  logic                        io_rst,
  input  logic [NUM_REQ-1:0]          io_in_valid,
  output logic [NUM_REQ-1:0]          io_in_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   io_in_bits,
  output logic                        io_out_valid,
  input  logic                        io_out_ready,
  output logic [DATA_W-1:0]           io_out_bits,
  output logic [grant_w(NUM_REQ)-1:0] io_grant_id,
  output logic                        io_busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]   io_stat_beats
`endif
);

  localparam int unsigned GRANT_W = grant_w(NUM_REQ);
  localparam int unsigned BEAT_W  = beat_w(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [GRANT_W-1:0] pick_c;
  logic               any_req_c;
  logic               sel_valid_c;
  logic [DATA_W-1:0]  sel_bits_c;
  logic               xfer_c;

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i        (io_in_valid),
    .last_grant_i (grant_q),
    .pick_c_o     (pick_c),
    .any_req_c_o  (any_req_c)
  );

  // grant_q doubles as last_grant: it is only rewritten when a new grant starts.
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_q    <= IDLE;
      grant_q    <= GRANT_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Outputs are suppressed during reset so an in-flight beat is never handshaken.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    sel_valid_c  = 1'b0;
    sel_bits_c   = '0;
    io_out_valid = 1'b0;
    io_out_bits  = '0;
    io_in_ready  = '0;
    io_busy      = 1'b0;
    xfer_c       = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_valid_c = io_in_valid[i];
        sel_bits_c  = io_in_bits[i*DATA_W +: DATA_W];
      end
    end
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          grant_d    = pick_c;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!io_rst) begin
          io_busy      = 1'b1;
          io_out_valid = sel_valid_c;
          io_out_bits  = sel_bits_c;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            io_in_ready[i] = io_out_ready && (grant_q == GRANT_W'(i));
          end
        end
        xfer_c = io_out_valid && io_out_ready;
        if (!sel_valid_c) begin
          state_d = IDLE;
        end else if (xfer_c) begin
          if (beat_cnt_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_grant_id = grant_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];
  logic [STAT_W-1:0] stat_d [NUM_REQ];

  always_comb begin
    io_stat_beats = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      stat_d[i] = stat_q[i];
      if (xfer_c && (grant_q == GRANT_W'(i)) && (stat_q[i] != '1)) begin
        stat_d[i] = stat_q[i] + STAT_W'(1);
      end
      io_stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
    end
  end

  always_ff @(posedge io_clk) begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (io_rst) stat_q[i] <= '0;
      else        stat_q[i] <= stat_d[i];
    end
  end
`endif

endmodule
